serial_adder: RTL

Multi-cycle add/subtract unit for WIDTH-bit operands. It processes CHUNK bits per clock using a registered carry between chunks. It generalises the single-bit full adder to parametrised width with a start/busy/done handshake, an optional subtract mode, and signed-overflow reporting. It serves datapaths that need wide arithmetic without a full-width carry chain in one cycle.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_chunk_adder.sv | 29 ++
 rtl/serial_adder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and elaboration helpers for serial_adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_legal(input int width, input int chunk);
        return (width >= 1) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/serial_adder_chunk_adder.sv
// rtl/serial_adder_chunk_adder.sv - combinational CHUNK-bit ripple adder slice
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    // carry into the MSB is what signed overflow is judged against
    assign cout  = carry[CHUNK];
    assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle add/subtract, CHUNK bits per clock
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    input  logic             sub_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_o,
    output logic             ovf_o
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    generate
        if (!params_legal(WIDTH, CHUNK)) begin : g_bad_params
            $error("serial_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_next;
    logic [WIDTH-1:0] sum_q;
    logic             co_q, ovf_q;
    logic             accept, step, last;

    logic [CHUNK-1:0] a_chunk, b_chunk, ch_sum;
    logic             ch_co, ch_cmsb;
    int               base;

    assign base = int'(idx_q) * CHUNK;

    always_comb begin
        a_chunk  = a_q[base +: CHUNK];
        b_chunk  = b_q[base +: CHUNK];
        acc_next = acc_q;
        acc_next[base +: CHUNK] = ch_sum;
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_chunk),
        .b     (b_chunk),
        .cin   (carry_q),
        .sum   (ch_sum),
        .cout  (ch_co),
        .c_msb (ch_cmsb)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                step = 1'b1;
                if (idx_q == LAST_IDX) begin
                    last    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                // subtract is A + ~B + ~c_in, so B and the carry are folded in at capture
                a_q     <= a_i;
                b_q     <= sub_i ? ~b_i : b_i;
                carry_q <= c_i ^ sub_i;
                idx_q   <= '0;
                acc_q   <= '0;
            end
            if (step) begin
                acc_q   <= acc_next;
                carry_q <= ch_co;
                if (last) begin
                    idx_q <= '0;
                    sum_q <= acc_next;
                    co_q  <= ch_co;
                    ovf_q <= ch_co ^ ch_cmsb;
                end else begin
                    idx_q <= idx_q + CNT_W'(1);
                end
            end
        end
    end

    assign busy_o = (state_q == ST_BUSY);
    assign done_o = (state_q == ST_DONE);
    assign sum_o  = sum_q;
    assign c_o    = co_q;
    assign ovf_o  = ovf_q;

endmodule
